// File: rtl/bcd_pkg.sv
// Shared constants and FSM state type for the serial BCD-to-binary converter.
// Optional operand checking is enabled with the BCD_CHECK_EN macro.
package bcd_pkg;

    localparam int BCD_W     = 10;
    localparam int BIN_W     = 8;
    localparam int DIGIT_W   = 4;
    localparam int NUM_STEPS = 8;
    localparam int CNT_W     = $clog2(NUM_STEPS);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_DONE
    } state_t;

    // Digit over 9, or a well-formed operand whose value exceeds 8 bits.
    function automatic logic bcd_invalid(input logic [BCD_W-1:0] bcd);
        logic [BCD_W-1:0] v;
        logic             bad_digit;
        bad_digit = (bcd[3:0] > 4'd9) || (bcd[7:4] > 4'd9);
        v = BCD_W'(bcd[9:8]) * BCD_W'(100)
          + BCD_W'(bcd[7:4]) * BCD_W'(10)
          + BCD_W'(bcd[3:0]);
        return bad_digit || (v > BCD_W'(255));
    endfunction

endpackage

// File: rtl/sub_3_if_ge_8.sv
// Reverse double-dabble digit correction: subtract 3 from a digit >= 8.
// Purely combinational, one instance per corrected BCD digit.
module sub_3_if_ge_8
    import bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] i_digit,
    output logic [DIGIT_W-1:0] o_digit
);

    logic w_ge8;

    assign w_ge8   = i_digit[DIGIT_W-1];
    assign o_digit = w_ge8 ? (i_digit - DIGIT_W'(3)) : i_digit;

endmodule

// File: rtl/bcd_to_bin_8_bit.sv
// Serial 3-digit BCD to 8-bit binary converter, one result bit per cycle.
// Define BCD_CHECK_EN to flag malformed or >255 operands via err_o.
module bcd_to_bin_8_bit
    import bcd_pkg::*;
(
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [BCD_W-1:0] bcd_i,
    output logic             busy_o,
    output logic             bit_o,
    output logic             bit_vld_o,
    output logic [BIN_W-1:0] bin_o,
    output logic             done_o,
    output logic             err_o
);

    state_t             r_state;
    logic [BCD_W-1:0]   r_work;
    logic [BIN_W-1:0]   r_res;
    logic [CNT_W-1:0]   r_cnt;
    logic [BIN_W-1:0]   r_bin;

    logic [BCD_W-1:0]   w_shifted;
    logic [DIGIT_W-1:0] w_units;
    logic [DIGIT_W-1:0] w_tens;
    logic [BCD_W-1:0]   w_work_next;
    logic [BIN_W-1:0]   w_res_next;
    logic               w_last;
    logic               w_busy;
    logic [BIN_W-1:0]   w_bin_done;

    assign w_shifted  = {1'b0, r_work[BCD_W-1:1]};
    assign w_res_next = {r_work[0], r_res[BIN_W-1:1]};
    assign w_last     = (r_cnt == CNT_W'(NUM_STEPS - 1));
    assign w_busy     = (r_state == ST_SHIFT);

    sub_3_if_ge_8 u_units (
        .i_digit (w_shifted[3:0]),
        .o_digit (w_units)
    );

    sub_3_if_ge_8 u_tens (
        .i_digit (w_shifted[7:4]),
        .o_digit (w_tens)
    );

    // Hundreds never exceeds 2, so it shifts through uncorrected.
    assign w_work_next = {w_shifted[9:8], w_tens, w_units};

`ifdef BCD_CHECK_EN
    logic r_flag;
    logic r_err;

    assign w_bin_done = r_flag ? '0 : w_res_next;
    assign err_o      = r_err;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flag <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            if (r_state != ST_SHIFT && start_i) begin
                r_flag <= bcd_invalid(bcd_i);
            end
            if (w_busy && w_last) begin
                r_err <= r_flag;
            end
        end
    end
`else
    assign w_bin_done = w_res_next;
    assign err_o      = 1'b0;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
            r_work  <= '0;
            r_res   <= '0;
            r_cnt   <= '0;
            r_bin   <= '0;
        end else begin
            unique case (r_state)
                ST_IDLE, ST_DONE: begin
                    if (start_i) begin
                        r_state <= ST_SHIFT;
                        r_work  <= bcd_i;
                        r_res   <= '0;
                        r_cnt   <= '0;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SHIFT: begin
                    r_work <= w_work_next;
                    r_res  <= w_res_next;
                    r_cnt  <= r_cnt + CNT_W'(1);
                    if (w_last) begin
                        r_state <= ST_DONE;
                        r_bin   <= w_bin_done;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy_o    = w_busy;
    assign bit_vld_o = w_busy;
    assign bit_o     = w_busy & r_work[0];
    assign done_o    = (r_state == ST_DONE);
    assign bin_o     = r_bin;

endmodule

// File: tb/tb_bcd_to_bin_8_bit.sv
// Directed bench for bcd_to_bin_8_bit; expectations are hand-computed.
// Honours BCD_CHECK_EN when it is defined for the build.
module tb_bcd_to_bin_8_bit;

    logic       clk;
    logic       rst;
    logic       start;
    logic [9:0] bcd;
    logic       busy;
    logic       bit_o;
    logic       bit_vld;
    logic [7:0] bin;
    logic       done;
    logic       err;

    int n_vec;
    int n_err;

    bcd_to_bin_8_bit dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_i   (start),
        .bcd_i     (bcd),
        .busy_o    (busy),
        .bit_o     (bit_o),
        .bit_vld_o (bit_vld),
        .bin_o     (bin),
        .done_o    (done),
        .err_o     (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change at negedge; the accept happens on the next posedge.
    task automatic start_conv(input logic [9:0] b);
        @(negedge clk);
        start = 1'b1;
        bcd   = b;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Follows 8 SHIFT cycles, then the DONE cycle (8 edges after accept).
    task automatic check_conv(input string nm, input logic [7:0] bits,
                              input logic [7:0] exp_bin, input logic exp_err);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++;
            if ({busy, bit_vld, bit_o, done} !== {1'b1, 1'b1, bits[i], 1'b0}) begin
                n_err++;
                $display("FAIL %s step %0d: busy/vld/bit/done=%b required %b",
                         nm, i, {busy, bit_vld, bit_o, done},
                         {1'b1, 1'b1, bits[i], 1'b0});
            end
        end
        @(negedge clk);
        n_vec++;
        if ({done, busy, bit_vld, bin, err} !== {1'b1, 1'b0, 1'b0, exp_bin, exp_err}) begin
            n_err++;
            $display("FAIL %s done: done=%b busy=%b vld=%b bin=%h err=%b required 1 0 0 %h %b",
                     nm, done, busy, bit_vld, bin, err, exp_bin, exp_err);
        end
    endtask

    task automatic check_idle_after(input string nm, input logic [7:0] exp_bin);
        @(negedge clk);
        n_vec++;
        if ({done, busy, bin} !== {1'b0, 1'b0, exp_bin}) begin
            n_err++;
            $display("FAIL %s idle: done=%b busy=%b bin=%h required 0 0 %h",
                     nm, done, busy, bin, exp_bin);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b1;
        bcd = 10'h3FF;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_vec++;
        if ({busy, bit_o, bit_vld, bin, done, err} !== 13'b0) begin
            n_err++;
            $display("FAIL reset: outs=%b required %b",
                     {busy, bit_o, bit_vld, bin, done, err}, 13'b0);
        end
        rst = 1'b0;
        start = 1'b0;
        bcd = '0;
    endtask

    task automatic test_max;
        start_conv(10'b10_0101_0101);
        check_conv("conv255", 8'hFF, 8'hFF, 1'b0);
        check_idle_after("conv255", 8'hFF);
    endtask

    task automatic test_128;
        start_conv(10'b01_0010_1000);
        check_conv("conv128", 8'h80, 8'h80, 1'b0);
        check_idle_after("conv128", 8'h80);
    endtask

    task automatic test_back_to_back;
        start_conv(10'b00_0000_0000);
        check_conv("b2b_zero", 8'h00, 8'h00, 1'b0);
        start = 1'b1;
        bcd   = 10'b00_1001_1001;
        @(posedge clk);
        #1 start = 1'b0;
        check_conv("b2b_99", 8'h63, 8'h63, 1'b0);
        check_idle_after("b2b_99", 8'h63);
    endtask

    task automatic test_ignore_start;
        logic [7:0] bits;
        bits = 8'd42;
        start_conv(10'b00_0100_0010);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            n_vec++;
            if ({busy, bit_vld, bit_o} !== {1'b1, 1'b1, bits[i]}) begin
                n_err++;
                $display("FAIL ignore step %0d: busy/vld/bit=%b required %b",
                         i, {busy, bit_vld, bit_o}, {1'b1, 1'b1, bits[i]});
            end
            start = (i == 3);
            bcd   = (i == 3) ? 10'b10_0101_0101 : 10'b00_0100_0010;
        end
        start = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({done, bin} !== {1'b1, 8'd42}) begin
            n_err++;
            $display("FAIL ignore done: done=%b bin=%h required 1 %h", done, bin, 8'd42);
        end
        check_idle_after("ignore", 8'd42);
    endtask

    task automatic test_reset_mid;
        logic [7:0] bits;
        int         seen;
        bits = 8'hFF;
        seen = 0;
        start_conv(10'b10_0101_0101);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++;
            if ({busy, bit_o} !== {1'b1, bits[i]}) begin
                n_err++;
                $display("FAIL rstmid step %0d: busy/bit=%b required 11", i, {busy, bit_o});
            end
        end
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        rst   = 1'b0;
        start = 1'b0;
        n_vec++;
        if ({busy, bit_vld, bin, done, err} !== 12'b0) begin
            n_err++;
            $display("FAIL rstmid after: busy=%b vld=%b bin=%h done=%b err=%b required all 0",
                     busy, bit_vld, bin, done, err);
        end
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done || busy) seen++;
        end
        n_vec++;
        if (seen !== 0) begin
            n_err++;
            $display("FAIL rstmid no_done: active cycles=%0d required 0", seen);
        end
    endtask

    task automatic test_bad_operands;
`ifdef BCD_CHECK_EN
        start_conv(10'b00_0000_1010);
        check_conv("bad_unitsA", 8'h0A, 8'h00, 1'b1);
        start_conv(10'b10_1001_1001);
        check_conv("bad_299", 8'h2B, 8'h00, 1'b1);
        start_conv(10'b00_0001_0111);
        check_conv("good_17", 8'h11, 8'h11, 1'b0);
`else
        start_conv(10'b00_0000_1010);
        check_conv("raw_unitsA", 8'h0A, 8'h0A, 1'b0);
        start_conv(10'b10_1001_1001);
        check_conv("raw_299", 8'h2B, 8'h2B, 1'b0);
`endif
        check_idle_after("bad_ops_end", bin);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        rst   = 1'b0;
        start = 1'b0;
        bcd   = '0;
        test_reset;
        test_max;
        test_128;
        test_back_to_back;
        test_ignore_start;
        test_reset_mid;
        test_bad_operands;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
